// File: rtl/irq_ctrl.sv
// Purpose : 68000 interrupt controller; edge-latched pending bits, mask, level encode, IACK vectoring.
// Latency : source rise -> pend 1 edge, -> ipl_n 2 edges (+2 with IRQ_CTRL_SYNC_EN); bus/IACK data 1 cycle.
// Backpres: none; every strobed or IACK cycle is acknowledged on the following cycle.
//
// Optional build macro: IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on each irq_src bit.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   data_write/data_read    16-bit bus data in / registered read data or IACK vector out
//   addr, uds, lds, rw      word select (addr[7:1]), byte strobes, 1=read
//   ack                     registered transfer acknowledge
//   iack, iack_level        interrupt-acknowledge cycle and the level being acknowledged
//   irq_src                 source requests, bit i = priority level i+1 (bit 6 = NMI)
//   ipl_n                   registered active-low encoded priority level

module irq_ctrl #(
    parameter logic [7:0] VECTOR_RESET = 8'h40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    input  logic [7:0]  addr,
    input  logic        uds,
    input  logic        lds,
    input  logic        rw,
    output logic        ack,
    input  logic        iack,
    input  logic [2:0]  iack_level,
    input  logic [6:0]  irq_src,
    output logic [2:0]  ipl_n
);

    localparam logic [6:0] REG_PEND   = 7'd0;
    localparam logic [6:0] REG_MASK   = 7'd1;
    localparam logic [6:0] REG_VBASE  = 7'd2;
    localparam logic [6:0] REG_STATUS = 7'd3;
    localparam logic [15:0] SPURIOUS_VEC = 16'h0018;

    // ------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------
    logic [6:0] src_s;

`ifdef IRQ_CTRL_SYNC_EN
    logic [6:0] sync1_q;
    logic [6:0] sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    // Sources are on-chip and already synchronous to clk.
    assign src_s = irq_src;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [6:0]  prev_q;
    logic [6:0]  pend_q, pend_d;
    logic [6:0]  mask_q, mask_d;
    logic [7:0]  vbase_q, vbase_d;
    logic        iack_q;
    logic [15:0] data_read_q, data_read_d;
    logic        ack_q;
    logic [2:0]  ipl_n_q;

    logic [6:0]  rise;
    logic [6:0]  act;
    logic [2:0]  lvl;
    logic [6:0]  pend_clr;
    logic [15:0] rd_val;
    logic [6:0]  reg_sel;
    logic        iack_first;
    logic        iack_hit;
    logic [7:0]  act_ext;
    logic [7:0]  lvl_oh;

    assign rise    = src_s & ~prev_q;
    assign act     = pend_q & mask_q;
    assign reg_sel = addr[7:1];

    // Only the first cycle of an IACK cycle acts; later cycles just hold the vector.
    assign iack_first = iack & ~iack_q;

    // Index 0 of act_ext is a constant 0 so level 0 never hits.
    assign act_ext  = {act, 1'b0};
    assign iack_hit = act_ext[iack_level];
    assign lvl_oh   = 8'b1 << iack_level;

    // Highest active bit wins; later iterations overwrite earlier ones.
    always_comb begin
        lvl = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (act[i]) begin
                lvl = 3'(i + 1);
            end
        end
    end

    // Register read mux; every register lives in the low byte.
    always_comb begin
        rd_val = 16'h0000;
        case (reg_sel)
            REG_PEND:   rd_val = {9'b0, pend_q};
            REG_MASK:   rd_val = {9'b0, mask_q};
            REG_VBASE:  rd_val = {8'b0, vbase_q};
            REG_STATUS: rd_val = {13'b0, lvl};
            default:    rd_val = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic: IACK takes priority over normal bus access.
    // ------------------------------------------------------------------
    always_comb begin
        pend_clr    = 7'b0;
        mask_d      = mask_q;
        vbase_d     = vbase_q;
        data_read_d = data_read_q;

        if (iack) begin
            if (iack_first) begin
                if (iack_hit) begin
                    data_read_d = {8'h00, vbase_q + {5'b0, iack_level}};
                    pend_clr    = lvl_oh[7:1];
                end else begin
                    data_read_d = SPURIOUS_VEC;
                end
            end
        end else if (uds || lds) begin
            if (rw) begin
                data_read_d = rd_val;
            end else if (lds) begin
                case (reg_sel)
                    REG_PEND:  pend_clr = data_write[6:0];
                    REG_MASK:  mask_d   = data_write[6:0];
                    REG_VBASE: vbase_d  = data_write[7:0];
                    default:   ;
                endcase
            end
        end

        // A new edge in the same cycle as a clear keeps the bit pending.
        pend_d = (pend_q & ~pend_clr) | rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            vbase_q     <= VECTOR_RESET;
            iack_q      <= 1'b0;
            data_read_q <= '0;
            ack_q       <= 1'b0;
            ipl_n_q     <= 3'b111;
        end else begin
            prev_q      <= src_s;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            vbase_q     <= vbase_d;
            iack_q      <= iack;
            data_read_q <= data_read_d;
            ack_q       <= iack | uds | lds;
            ipl_n_q     <= ~lvl;
        end
    end

    assign data_read = data_read_q;
    assign ack       = ack_q;
    assign ipl_n     = ipl_n_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Purpose : directed self-checking bench for irq_ctrl using an expected-value scoreboard queue.
// Latency : checks sampled on the falling edge, half a cycle after the DUT's active edge.
// Backpres: n/a.

module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic [7:0]  addr;
    logic        uds;
    logic        lds;
    logic        rw;
    logic        ack;
    logic        iack;
    logic [2:0]  iack_level;
    logic [6:0]  irq_src;
    logic [2:0]  ipl_n;

    irq_ctrl #(.VECTOR_RESET(8'h40)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_write (data_write),
        .data_read  (data_read),
        .addr       (addr),
        .uds        (uds),
        .lds        (lds),
        .rw         (rw),
        .ack        (ack),
        .iack       (iack),
        .iack_level (iack_level),
        .irq_src    (irq_src),
        .ipl_n      (ipl_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   passed = 0;
    int   total  = 0;
    int   failed = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            failed++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.val) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] exp_v, input string tag);
        push(tag, exp_v);
        push({tag, "_ack"}, 16'h0001);
        addr = a; rw = 1'b1; uds = 1'b1; lds = 1'b1;
        tick();
        pop_check(data_read);
        pop_check({15'b0, ack});
        uds = 1'b0; lds = 1'b0;
    endtask

    // Write lands on the next rising edge; returns at the following falling edge.
    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        addr = a; rw = 1'b0; data_write = d; uds = 1'b1; lds = 1'b1;
        tick();
        uds = 1'b0; lds = 1'b0; rw = 1'b1;
    endtask

    task automatic chk_ipl(input logic [2:0] v, input string tag);
        push(tag, {13'b0, v});
        pop_check({13'b0, ipl_n});
    endtask

    // Called right after the falling edge that follows the rising edge sampling a source rise.
    task automatic after_rise(input logic [2:0] pre, input logic [2:0] post, input string tag);
        repeat (SYNC_LAT) tick();
        chk_ipl(pre, {tag, "_pre"});
        tick();
        chk_ipl(post, tag);
    endtask

    task automatic iack_cyc(input logic [2:0] lv, input logic [15:0] exp_v, input string tag);
        iack = 1'b1; iack_level = lv;
        push(tag, exp_v);
        push({tag, "_ack"}, 16'h0001);
        tick();
        pop_check(data_read);
        pop_check({15'b0, ack});
        // Held IACK: no further action, vector held, ack stays up.
        push({tag, "_hold"}, exp_v);
        push({tag, "_hold_ack"}, 16'h0001);
        tick();
        pop_check(data_read);
        pop_check({15'b0, ack});
        iack = 1'b0;
        tick();
        push({tag, "_ack_drop"}, 16'h0000);
        pop_check({15'b0, ack});
    endtask

    initial begin
        reset_n = 1'b0; data_write = '0; addr = '0; uds = 1'b0; lds = 1'b0;
        rw = 1'b1; iack = 1'b0; iack_level = '0; irq_src = '0;

        // ---------------- reset ----------------
        tick();
        chk_ipl(3'b111, "rst_ipl");
        push("rst_ack", 16'h0000);  pop_check({15'b0, ack});
        push("rst_data", 16'h0000); pop_check(data_read);
        reset_n = 1'b1;
        tick();
        rd(8'h04, 16'h0040, "vbase_rst");
        rd(8'h02, 16'h0000, "mask_rst");
        tick();
        push("ack_idle", 16'h0000); pop_check({15'b0, ack});

        // ---------------- basic latch + level ----------------
        wr(8'h02, 16'h007F);
        tick();
        irq_src = 7'h10;
        tick();
        irq_src = 7'h00;
        after_rise(3'b111, 3'b010, "src4_ipl");
        rd(8'h00, 16'h0010, "pend_src4");
        rd(8'h06, 16'h0005, "status_l5");

        // ---------------- priority + W1C ----------------
        wr(8'h00, 16'h0010);
        tick();
        chk_ipl(3'b111, "clr4_ipl");
        irq_src = 7'h22;
        tick();
        after_rise(3'b111, ~3'd6, "prio_ipl6");
        wr(8'h00, 16'h0020);
        tick();
        chk_ipl(~3'd2, "prio_ipl2");
        wr(8'h00, 16'h0002);
        tick();
        chk_ipl(3'b111, "prio_none");
        // Level still held high: no re-latch.
        repeat (3) tick();
        rd(8'h00, 16'h0000, "held_no_relatch");
        irq_src = 7'h00;
        tick();

        // ---------------- IACK hit ----------------
        irq_src = 7'h40;
        tick();
        irq_src = 7'h00;
        after_rise(3'b111, 3'b000, "src6_ipl");
        iack_cyc(3'd7, 16'h0047, "iack7");
        rd(8'h00, 16'h0000, "pend6_cleared");
        chk_ipl(3'b111, "iack7_ipl");

        // ---------------- spurious IACK, then vector wrap ----------------
        irq_src = 7'h02;
        tick();
        irq_src = 7'h00;
        after_rise(3'b111, ~3'd2, "src1_ipl");
        iack_cyc(3'd3, 16'h0018, "iack_spur3");
        rd(8'h00, 16'h0002, "spur_pend_kept");
        iack_cyc(3'd0, 16'h0018, "iack_spur0");
        wr(8'h04, 16'h00FE);
        iack_cyc(3'd2, 16'h0000, "iack_wrap");
        rd(8'h00, 16'h0000, "wrap_pend_cleared");

        // ---------------- mask ----------------
        wr(8'h02, 16'h0000);
        tick();
        irq_src = 7'h04;
        tick();
        irq_src = 7'h00;
        after_rise(3'b111, 3'b111, "masked_ipl");
        rd(8'h00, 16'h0004, "masked_pend");
        iack_cyc(3'd3, 16'h0018, "iack_masked");
        wr(8'h02, 16'h0004);
        chk_ipl(3'b111, "unmask_pre");
        tick();
        chk_ipl(~3'd3, "unmask_ipl");

        // ---------------- byte lanes / unused address ----------------
        addr = 8'h02; rw = 1'b0; data_write = 16'h007F; uds = 1'b1; lds = 1'b0;
        tick();
        uds = 1'b0; rw = 1'b1;
        rd(8'h02, 16'h0004, "uds_only_ignored");
        wr(8'h20, 16'hFFFF);
        rd(8'h20, 16'h0000, "unused_addr");

        // ---------------- set wins over W1C ----------------
        wr(8'h00, 16'h0004);
        rd(8'h00, 16'h0000, "w1c_plain");
        irq_src = 7'h08;
        tick();
        after_rise(3'b111, 3'b111, "src3_masked");
        irq_src = 7'h00;
        irq_src = 7'h04;
        repeat (SYNC_LAT) tick();
        // pend[3] set; clear bit 3 while bit 2 rises on the same edge as a clear of bit 2.
        wr(8'h00, 16'h000C);
        rd(8'h00, 16'h0004, "set_beats_clear");
        irq_src = 7'h00;
        tick();

        // ---------------- reset during IACK ----------------
        chk_ipl(~3'd3, "pre_rst_ipl");
        iack = 1'b1; iack_level = 3'd3;
        push("rst_iack_data", 16'h0001);
        tick();
        pop_check(data_read);
        #2 reset_n = 1'b0;
        #1;
        push("rst_async_ack", 16'h0000); pop_check({15'b0, ack});
        chk_ipl(3'b111, "rst_async_ipl");
        push("rst_async_data", 16'h0000); pop_check(data_read);
        iack = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        rd(8'h04, 16'h0040, "vbase_after_rst");
        rd(8'h00, 16'h0000, "pend_after_rst");

        if (sb_q.size() != 0) begin
            total++;
            failed++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
